// File: rtl/vga_pkg.sv
// Shared raster timing constants for the video pipeline.
// Each display mode gets its own constant set; XGA (1024x768 @ 60 Hz) is the default.
package vga_pkg;

  localparam int unsigned XGA_H_VISIBLE = 1024;
  localparam int unsigned XGA_H_FRONT   = 24;
  localparam int unsigned XGA_H_SYNC    = 136;
  localparam int unsigned XGA_H_BACK    = 160;
  localparam int unsigned XGA_H_TOTAL   =
    XGA_H_VISIBLE + XGA_H_FRONT + XGA_H_SYNC + XGA_H_BACK;

  localparam int unsigned XGA_V_VISIBLE = 768;
  localparam int unsigned XGA_V_FRONT   = 3;
  localparam int unsigned XGA_V_SYNC    = 6;
  localparam int unsigned XGA_V_BACK    = 29;
  localparam int unsigned XGA_V_TOTAL   =
    XGA_V_VISIBLE + XGA_V_FRONT + XGA_V_SYNC + XGA_V_BACK;

  // Sync pulse occupies [START, END] inclusive, in counter units.
  localparam int unsigned XGA_HS_START = XGA_H_VISIBLE + XGA_H_FRONT;
  localparam int unsigned XGA_HS_END   = XGA_HS_START + XGA_H_SYNC - 1;
  localparam int unsigned XGA_VS_START = XGA_V_VISIBLE + XGA_V_FRONT;
  localparam int unsigned XGA_VS_END   = XGA_VS_START + XGA_V_SYNC - 1;

  localparam int unsigned H_CNT_W = $clog2(XGA_H_TOTAL);
  localparam int unsigned V_CNT_W = $clog2(XGA_V_TOTAL);

endpackage

// File: rtl/wrap_counter.sv
// Up-counter with enable that wraps explicitly to zero after reaching MAX.
module wrap_counter #(
  parameter int unsigned W   = 11,
  parameter int unsigned MAX = 1343
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] TERM = W'(MAX);

  // wrap flags the terminal value; the caller qualifies it with its own enable.
  assign wrap = (count == TERM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ce) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_xga.sv
// Raster timing generator: counters plus registered sync/active/coordinate/strobe outputs.
module vga_timing_xga
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = XGA_H_VISIBLE,
  parameter int unsigned H_FRONT         = XGA_H_FRONT,
  parameter int unsigned H_SYNC          = XGA_H_SYNC,
  parameter int unsigned H_BACK          = XGA_H_BACK,
  parameter int unsigned V_VISIBLE       = XGA_V_VISIBLE,
  parameter int unsigned V_FRONT         = XGA_V_FRONT,
  parameter int unsigned V_SYNC          = XGA_V_SYNC,
  parameter int unsigned V_BACK          = XGA_V_BACK,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               inclk,
  input  logic               rst_n,
  input  logic               ce,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [H_CNT_W-1:0] x,
  output logic [V_CNT_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [H_CNT_W-1:0] H_VIS_C  = H_CNT_W'(H_VISIBLE);
  localparam logic [H_CNT_W-1:0] HS_START = H_CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [V_CNT_W-1:0] V_VIS_C  = V_CNT_W'(V_VISIBLE);
  localparam logic [V_CNT_W-1:0] VS_START = V_CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               h_wrap;
  logic               v_wrap_unused;
  logic               v_ce;

  assign v_ce = ce & h_wrap;

  wrap_counter #(
    .W   (H_CNT_W),
    .MAX (H_TOTAL - 1)
  ) u_h_cnt (
    .clk   (inclk),
    .rst_n (rst_n),
    .ce    (ce),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  wrap_counter #(
    .W   (V_CNT_W),
    .MAX (V_TOTAL - 1)
  ) u_v_cnt (
    .clk   (inclk),
    .rst_n (rst_n),
    .ce    (v_ce),
    .count (v_cnt),
    .wrap  (v_wrap_unused)
  );

  // Outputs decode the pre-increment counters, so they trail the counters by one cycle.
  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      hsync       <= SYNC_ACTIVE_LOW;
      vsync       <= SYNC_ACTIVE_LOW;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      x           <= h_cnt;
      y           <= v_cnt;
      active      <= (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
      hsync       <= ((h_cnt >= HS_START) && (h_cnt <= HS_END)) ^ SYNC_ACTIVE_LOW;
      vsync       <= ((v_cnt >= VS_START) && (v_cnt <= VS_END)) ^ SYNC_ACTIVE_LOW;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
